// File: rtl/fifo_rd_pack.sv
// fifo_rd_pack: pops words from a 1-cycle-latency FIFO read port, pairs them
// into a double-width word and delivers it on a valid/ready handshake.
module fifo_rd_pack #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_W-1:0]     fifo_rd_data,
  input  logic                  flush,
  output logic [2*DATA_W-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int unsigned OUT_W = 2 * DATA_W;

  // Hold occupancy: nothing, low half held, complete pair presented.
  typedef enum logic [1:0] {
    H_EMPTY = 2'd0,
    H_LO    = 2'd1,
    H_FULL  = 2'd2
  } hold_e;

  hold_e             h;
  logic              p;
  logic              d;
  logic [DATA_W-1:0] lo;

  logic       accept_c;
  logic       arrive_c;
  logic [1:0] occ_c;
  logic [2:0] need_c;

  // Handshake, arrival qualification and pop decision.
  // A flush also discards a word landing in the flush cycle itself, so a
  // stale word can never pair with data popped after the flush.
  always_comb begin
    accept_c   = out_valid & out_ready;
    arrive_c   = p & ~d & ~flush;
    occ_c      = accept_c ? 2'd0 : 2'(h);
    need_c     = 3'(occ_c) + 3'(p);
    fifo_rd_en = ~rst & ~fifo_empty & ~flush & (need_c < 3'd2);
  end

  // Pair assembly, output register, drop flag and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h         <= H_EMPTY;
      p         <= 1'b0;
      d         <= 1'b0;
      lo        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      p <= fifo_rd_en;
      d <= flush & p;

      if (accept_c) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end

      if (arrive_c && (accept_c || h == H_EMPTY)) begin
        lo        <= fifo_rd_data;
        h         <= H_LO;
        out_valid <= 1'b0;
      end else if (arrive_c && h == H_LO) begin
        out_data  <= OUT_W'({fifo_rd_data, lo});
        out_valid <= 1'b1;
        h         <= H_FULL;
      end else if (accept_c) begin
        h         <= H_EMPTY;
        out_valid <= 1'b0;
      end else if (flush && h == H_LO) begin
        h  <= H_EMPTY;
        lo <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_pack.sv
// tb_fifo_rd_pack: directed and randomized checks of fifo_rd_pack against a
// queue-based reference of the pairing rules.
module tb_fifo_rd_pack;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int          CNT_MOD = 1 << CNT_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [DATA_W-1:0]   fifo_rd_data;
  logic                flush;
  logic [2*DATA_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    word_cnt;

  always #5 clk = ~clk;

  fifo_rd_pack #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .flush        (flush),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .word_cnt     (word_cnt)
  );

  // FIFO contents and stall control
  logic [DATA_W-1:0] fq[$];
  bit                stall;

  // reference state: words currently buffered, pop in flight, counter
  logic [DATA_W-1:0] m_buf[$];
  bit                m_fly;
  int                m_cnt;
  logic [DATA_W-1:0] fly_word;
  bit                obs_fly;
  logic [15:0]       last_acc;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_fly   = 1'b0;
    m_cnt   = 0;
    obs_fly = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    fq.push_back(w);
  endtask

  // one clock cycle: called at posedge+1, returns at the next posedge+1
  task automatic cycle();
    bit          e_valid;
    bit          e_acc;
    bit          e_rd;
    bit          obs_rd;
    int          occ;
    logic [15:0] e_data;
    fifo_empty = (fq.size() == 0) || stall;
    #1;
    e_valid = (m_buf.size() == 2);
    e_acc   = e_valid && out_ready;
    occ     = e_acc ? 0 : m_buf.size();
    e_rd    = !fifo_empty && !flush && (occ + int'(m_fly) < 2);
    obs_rd  = fifo_rd_en;
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(e_rd));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    if (e_valid) begin
      e_data = {m_buf[1], m_buf[0]};
      chk("out_data", 32'(out_data), 32'(e_data));
    end
    chk("word_cnt", 32'(word_cnt), 32'(m_cnt));
    chk("arrival_into_held_pair", 32'(obs_fly && out_valid && !out_ready), 32'(0));
    if (out_valid && out_ready) last_acc = out_data;
    // reference update
    if (e_acc) begin
      m_buf.delete();
      m_cnt = (m_cnt + 1) % CNT_MOD;
    end
    if (flush && m_buf.size() == 1) m_buf.delete();
    if (m_fly && !flush) m_buf.push_back(fly_word);
    m_fly   = e_rd;
    obs_fly = obs_rd;
    @(posedge clk);
    #1;
    if (obs_rd && fq.size() > 0) fifo_rd_data = fq.pop_front();
    fly_word = fifo_rd_data;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(0));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    chk({tag, "_out_data"}, 32'(out_data), 32'(0));
    chk({tag, "_word_cnt"}, 32'(word_cnt), 32'(0));
  endtask

  // synchronous-style reset pulse applied away from the clock edge
  task automatic pulse_reset();
    rst = 1'b1;
    fifo_empty = 1'b0;
    #1;
    check_reset_values("reset_pulse");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    out_ready    = 1'b0;
    stall        = 1'b0;
    fifo_empty   = 1'b0;
    fifo_rd_data = '0;
    fly_word     = '0;
    last_acc     = '0;
    model_reset();

    // reset state, FIFO reporting data available
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // basic stream
    out_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    run(12);
    chk("stream_last", 32'(last_acc), 32'h4433);
    chk("stream_cnt", 32'(word_cnt), 32'd2);

    // backpressure: pair held stable, pops stop
    out_ready = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88); push(8'h99); push(8'hAA);
    run(12);
    chk("bp_hold_data", 32'(out_data), 32'h6655);
    chk("bp_fifo_left", 32'(fq.size()), 32'd4);
    out_ready = 1'b1;
    run(16);
    chk("bp_last", 32'(last_acc), 32'hAA99);
    chk("bp_cnt", 32'(word_cnt), 32'd5);

    // odd word discarded by flush
    push(8'hA5);
    run(6);
    chk("odd_no_valid", 32'(out_valid), 32'(0));
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    push(8'h01); push(8'h02);
    run(8);
    chk("odd_flush_pair", 32'(last_acc), 32'h0201);

    // flush while a read is in flight
    push(8'h10); push(8'h50); push(8'h60);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    run(8);
    chk("inflight_flush_pair", 32'(last_acc), 32'h6050);

    // asynchronous reset with low half held and a read in flight
    push(8'h77); push(8'h88); push(8'h99);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    push(8'hAA);
    run(8);
    chk("async_restart_pair", 32'(last_acc), 32'hAA99);
    chk("async_restart_cnt", 32'(word_cnt), 32'd1);

    // counter wrap: 17 accepted words on a 4-bit counter
    pulse_reset();
    for (int i = 0; i < 34; i++) push(DATA_W'($urandom));
    run(70);
    chk("wrap_cnt", 32'(word_cnt), 32'd1);

    // randomized traffic, backpressure, stalls and flushes
    for (int i = 0; i < 800; i++) begin
      if (fq.size() < 6 && ($urandom % 2) == 0) push(DATA_W'($urandom));
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      stall     = ($urandom % 5) == 0;
      cycle();
    end
    flush     = 1'b0;
    stall     = 1'b0;
    out_ready = 1'b1;
    run(24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
